// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: tick/mode inputs and LED outputs of the pattern
// sequencer, grouped so the driver and the sequencer share one bundle.
interface led_pattern_seq_if #(
  parameter int WIDTH = 8
);
  logic             tick_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] leds;
  logic             step;
  logic             dir;

  modport master (
    output tick_in,
    output mode,
    input  leds,
    input  step,
    input  dir
  );

  modport slave (
    input  tick_in,
    input  mode,
    output leds,
    output step,
    output dir
  );
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: advances an LED pattern on each rising edge of a slow
// asynchronous tick; binary count, ring, bounce or hold chosen by mode.
module led_pattern_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  led_pattern_seq_if.slave bus
);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_RING = 2'b01;
  localparam logic [1:0] MODE_BNC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [1:0] ARM_MAX   = 2'd3;

  logic             s1;
  logic             s2;
  logic             s3;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             rise;

  logic [WIDTH-1:0] leds_q;
  logic [WIDTH-1:0] leds_nxt;
  logic             dir_q;
  logic             dir_nxt;
  logic             step_q;
  logic             one_hot;
  logic             msb;
  logic             lsb;

  // s3 only remembers s2, so a tick already high at reset
  // release shows no edge once the arm counter saturates.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      arm_cnt <= 2'd0;
    end else if (arm_cnt != ARM_MAX) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed = (arm_cnt == ARM_MAX);
  assign rise  = s2 & ~s3 & armed;

  assign msb     = leds_q[WIDTH-1];
  assign lsb     = leds_q[0];
  assign one_hot = (leds_q != '0) &&
                   ((leds_q & (leds_q - ONE)) == '0);

  always_comb begin
    leds_nxt = leds_q;
    dir_nxt  = dir_q;
    unique case (1'b1)
      (bus.mode == MODE_BIN): begin
        leds_nxt = leds_q + ONE;
      end
      (bus.mode == MODE_RING): begin
        if (leds_q == '0) begin
          leds_nxt = ONE;
        end else begin
          leds_nxt = {leds_q[WIDTH-2:0], msb};
        end
      end
      (bus.mode == MODE_BNC): begin
        // a lit bar that is not a single LED restarts from the right
        if (!one_hot) begin
          leds_nxt = ONE;
          dir_nxt  = 1'b1;
        end else if (dir_q) begin
          if (msb) begin
            dir_nxt  = 1'b0;
            leds_nxt = leds_q >> 1;
          end else begin
            leds_nxt = leds_q << 1;
          end
        end else begin
          if (lsb) begin
            dir_nxt  = 1'b1;
            leds_nxt = leds_q << 1;
          end else begin
            leds_nxt = leds_q >> 1;
          end
        end
      end
      (bus.mode == MODE_HOLD): begin
        leds_nxt = leds_q;
        dir_nxt  = dir_q;
      end
      default: begin
        leds_nxt = leds_q;
        dir_nxt  = dir_q;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      leds_q <= ONE;
      dir_q  <= 1'b1;
      step_q <= 1'b0;
    end else begin
      step_q <= rise & (bus.mode != MODE_HOLD);
      if (rise) begin
        leds_q <= leds_nxt;
        dir_q  <= dir_nxt;
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: randomized ticks and modes against a pattern model;
// a monitor pops expected steps from a queue and checks every cycle.
module tb_led_pattern_seq;

  localparam int W = 4;
  localparam int LAT = 3;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  always #5 clk_in = ~clk_in;

  led_pattern_seq_if #(.WIDTH(W)) bus();

  led_pattern_seq #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] leds;
    logic         dir;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int   m_leds;
  logic m_dir;
  logic [W-1:0] shown_leds;
  logic         shown_dir;

  always @(posedge clk_in) cyc = cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // pattern rules expressed on integers and LED positions
  task automatic model_tick(input logic [1:0] md);
    int v;
    int p;
    exp_t e;
    v = m_leds;
    case (md)
      2'b00: v = (v + 1) % (1 << W);
      2'b01: begin
        if (v == 0) v = 1;
        else v = ((v * 2) % (1 << W)) + (v >> (W - 1));
      end
      2'b10: begin
        if (v == 0 || (v & (v - 1)) != 0) begin
          v = 1;
          m_dir = 1'b1;
        end else begin
          p = 0;
          while ((1 << p) != v) p = p + 1;
          if (m_dir) begin
            if (p == W - 1) begin
              m_dir = 1'b0;
              p = p - 1;
            end else p = p + 1;
          end else begin
            if (p == 0) begin
              m_dir = 1'b1;
              p = p + 1;
            end else p = p - 1;
          end
          v = 1 << p;
        end
      end
      default: ;
    endcase
    m_leds = v;
    if (md != 2'b11) begin
      e.leds = W'(v);
      e.dir  = m_dir;
      e.cyc  = cyc;
      q.push_back(e);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst) begin
      if (bus.step) begin
        if (q.size() == 0) begin
          chk("spurious_step", 32'(bus.step), 32'd0);
        end else begin
          e = q.pop_front();
          chk("step_leds", 32'(bus.leds), 32'(e.leds));
          chk("step_dir", 32'(bus.dir), 32'(e.dir));
          chk("step_latency", 32'(cyc - e.cyc), 32'(LAT));
          shown_leds = e.leds;
          shown_dir  = e.dir;
        end
      end else begin
        chk("stable_leds", 32'(bus.leds), 32'(shown_leds));
        chk("stable_dir", 32'(bus.dir), 32'(shown_dir));
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    q.delete();
    m_leds = 1;
    m_dir = 1'b1;
    shown_leds = W'(1);
    shown_dir = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick(input logic [1:0] md, input int hi, input int lo);
    @(posedge clk_in);
    #1;
    bus.mode = md;
    @(posedge clk_in);
    #1;
    bus.tick_in = 1'b1;
    model_tick(md);
    repeat (hi) @(posedge clk_in);
    #1;
    bus.tick_in = 1'b0;
    repeat (lo) @(posedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  initial begin
    bus.tick_in = 1'b0;
    bus.mode = 2'b00;
    m_leds = 1;
    m_dir = 1'b1;
    shown_leds = W'(1);
    shown_dir = 1'b1;

    do_reset(3);
    @(negedge clk_in);
    chk("reset_leds", 32'(bus.leds), 32'h1);
    chk("reset_step", 32'(bus.step), 32'h0);
    chk("reset_dir", 32'(bus.dir), 32'h1);
    idle(5);

    tick(2'b00, 10, 10);
    @(negedge clk_in);
    chk("first_tick_leds", 32'(bus.leds), 32'h2);

    // count up to 1111, then wrap to 0000 and 0001
    for (int i = 0; i < 13; i++) tick(2'b00, 10, 10);
    @(negedge clk_in);
    chk("bin_preload", 32'(bus.leds), 32'hf);
    tick(2'b00, 10, 10);
    @(negedge clk_in);
    chk("bin_wrap", 32'(bus.leds), 32'h0);
    tick(2'b01, 10, 10);
    @(negedge clk_in);
    chk("ring_from_zero", 32'(bus.leds), 32'h1);

    do_reset(3);
    idle(5);
    for (int i = 0; i < 4; i++) tick(2'b01, 10, 10);
    @(negedge clk_in);
    chk("ring_full_turn", 32'(bus.leds), 32'h1);

    do_reset(3);
    idle(5);
    for (int i = 0; i < 7; i++) tick(2'b10, 10, 10);
    @(negedge clk_in);
    chk("bounce_seq_end", 32'(bus.leds), 32'h2);
    chk("bounce_seq_dir", 32'(bus.dir), 32'h1);

    do_reset(3);
    idle(5);
    tick(2'b00, 10, 10);
    tick(2'b00, 10, 10);
    tick(2'b10, 10, 10);
    @(negedge clk_in);
    chk("bounce_reload", 32'(bus.leds), 32'h1);

    for (int i = 0; i < 3; i++) tick(2'b11, 10, 10);
    @(negedge clk_in);
    chk("hold_leds", 32'(bus.leds), 32'h1);
    tick(2'b00, 10, 10);
    @(negedge clk_in);
    chk("hold_resume", 32'(bus.leds), 32'h2);

    // tick already high across reset release
    @(posedge clk_in);
    #1;
    bus.tick_in = 1'b1;
    bus.mode = 2'b00;
    do_reset(3);
    idle(12);
    @(negedge clk_in);
    chk("tick_high_reset", 32'(bus.leds), 32'h1);
    @(posedge clk_in);
    #1;
    bus.tick_in = 1'b0;
    idle(10);

    // reset arriving while an edge is still in the synchronizer
    @(posedge clk_in);
    #1;
    bus.tick_in = 1'b1;
    @(posedge clk_in);
    #1;
    do_reset(3);
    idle(10);
    @(negedge clk_in);
    chk("reset_mid_sync", 32'(bus.leds), 32'h1);
    @(posedge clk_in);
    #1;
    bus.tick_in = 1'b0;
    idle(10);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset($urandom_range(1, 4));
        idle(5);
      end
      tick(2'($urandom_range(0, 3)), $urandom_range(3, 12),
           $urandom_range(3, 12));
    end

    idle(10);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
